minbd_redirect_sb: RTL

- Parametrised successor to the MinBD redirect stage: one registered pipeline stage between the deflection/ejection stage and router output arbitration.
- Owns the side buffer as a FIFO of configurable depth.
- Re-injects buffered flits into free output slots.
- Forcibly redirects a live flit into the side buffer after a bounded starvation time, so buffered flits always make progress.
- Generalised in port count, flit width, buffer depth and starvation limit.

---
 rtl/minbd_pkg.sv | 12 +
 rtl/minbd_sb_fifo.sv | 50 +++++
 rtl/minbd_redirect_sb.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/minbd_pkg.sv
// Shared constants and flit type for the MinBD redirect stage.
package minbd_pkg;
   localparam int unsigned FLIT_W         = 11;
   localparam int unsigned FLIT_VALID_BIT = FLIT_W - 1;

   localparam int unsigned PORT_N = 0;
   localparam int unsigned PORT_S = 1;
   localparam int unsigned PORT_E = 2;
   localparam int unsigned PORT_W = 3;

   typedef logic [FLIT_W-1:0] flit_t;
endpackage

// File: rtl/minbd_sb_fifo.sv
// Side-buffer FIFO: combinational head, push accepted when full only if a pop frees an entry.
module minbd_sb_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned W     = 11
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic [W-1:0]                 push_data,
   input  logic                         pop,
   output logic [W-1:0]                 head,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         full,
   output logic                         empty
);
   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH+1);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end
endmodule

// File: rtl/minbd_redirect_sb.sv
// MinBD redirect stage: side buffer, re-injection and starvation-forced redirect.
// Optional statistics outputs enabled by defining MINBD_REDIRECT_STATS_EN.
module minbd_redirect_sb #(
   parameter int unsigned N_PORTS      = 4,
   parameter int unsigned FLIT_W       = minbd_pkg::FLIT_W,
   parameter int unsigned SB_DEPTH     = 4,
   parameter int unsigned STARVE_LIMIT = 8
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [N_PORTS*FLIT_W-1:0]         in_flits,
   input  logic [FLIT_W-1:0]                 buf_in_flit,
   input  logic                              buf_in_valid,
   output logic                              buf_in_ready,
   output logic [N_PORTS*FLIT_W-1:0]         out_flits,
   output logic [N_PORTS-1:0]                inject_vec,
   output logic [N_PORTS-1:0]                redirect_vec,
   output logic [$clog2(SB_DEPTH+1)-1:0]     sb_count,
   output logic                              sb_full,
   output logic                              sb_empty
`ifdef MINBD_REDIRECT_STATS_EN
   ,
   output logic [31:0]                       redirect_total,
   output logic [$clog2(STARVE_LIMIT+1)-1:0] starve_max
`endif
);
   import minbd_pkg::*;

   localparam int unsigned VB   = FLIT_W - 1;
   localparam int unsigned SC_W = $clog2(STARVE_LIMIT+1);
   localparam int unsigned RR_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

   logic [N_PORTS-1:0]        slot_valid;
   logic                      all_valid;
   logic [RR_W-1:0]           free_idx;
   logic                      found;
   logic [RR_W-1:0]           sel_idx;
   logic [RR_W-1:0]           rr_ptr;
   logic [SC_W-1:0]           starve_cnt;
   logic                      at_limit;
   logic                      user_push;
   logic                      do_redirect;
   logic                      do_reinject;
   logic [FLIT_W-1:0]         push_data;
   logic [FLIT_W-1:0]         head;
   logic [N_PORTS*FLIT_W-1:0] next_flits;
   logic [N_PORTS-1:0]        next_inject;
   logic [N_PORTS-1:0]        next_redirect;

   // Lowest-index invalid slot is the re-injection target.
   always_comb begin
      slot_valid = '0;
      free_idx   = '0;
      found      = 1'b0;
      for (int unsigned i = 0; i < N_PORTS; i++) begin
         slot_valid[i] = in_flits[i*FLIT_W + VB];
         if (!in_flits[i*FLIT_W + VB] && !found) begin
            free_idx = RR_W'(i);
            found    = 1'b1;
         end
      end
   end

   assign all_valid    = &slot_valid;
   assign at_limit     = (starve_cnt == SC_W'(STARVE_LIMIT));
   assign buf_in_ready = !sb_full && !at_limit;
   assign user_push    = buf_in_valid && buf_in_ready;
   assign do_redirect  = at_limit && all_valid && !sb_empty;
   assign do_reinject  = !sb_empty && !all_valid;
   assign sel_idx      = do_redirect ? rr_ptr : free_idx;

   // Redirect and upstream push never coincide: ready is low at the starvation limit.
   always_comb begin
      if (do_redirect) begin
         push_data = in_flits[rr_ptr*FLIT_W +: FLIT_W];
      end else begin
         push_data     = buf_in_flit;
         push_data[VB] = 1'b1;
      end
   end

   always_comb begin
      next_flits    = in_flits;
      next_inject   = '0;
      next_redirect = '0;
      if (do_redirect || do_reinject) begin
         next_flits[sel_idx*FLIT_W +: FLIT_W] = head;
         next_inject[sel_idx]                 = 1'b1;
      end
      if (do_redirect) next_redirect[rr_ptr] = 1'b1;
   end

   minbd_sb_fifo #(
      .DEPTH (SB_DEPTH),
      .W     (FLIT_W)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (user_push || do_redirect),
      .push_data (push_data),
      .pop       (do_reinject || do_redirect),
      .head      (head),
      .count     (sb_count),
      .full      (sb_full),
      .empty     (sb_empty)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         out_flits    <= '0;
         inject_vec   <= '0;
         redirect_vec <= '0;
         starve_cnt   <= '0;
         rr_ptr       <= RR_W'(PORT_N);
      end else begin
         out_flits    <= next_flits;
         inject_vec   <= next_inject;
         redirect_vec <= next_redirect;
         if (sb_empty || do_reinject || do_redirect) begin
            starve_cnt <= '0;
         end else if (!at_limit) begin
            starve_cnt <= starve_cnt + 1'b1;
         end
         if (do_redirect) begin
            rr_ptr <= (rr_ptr == RR_W'(N_PORTS-1)) ? '0 : rr_ptr + 1'b1;
         end
      end
   end

`ifdef MINBD_REDIRECT_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         redirect_total <= '0;
         starve_max     <= '0;
      end else begin
         if (do_redirect) redirect_total <= redirect_total + 1'b1;
         if (starve_cnt > starve_max) starve_max <= starve_cnt;
      end
   end
`endif
endmodule
